pkt_hdr_vec_builder: RTL and testbench



---
 rtl/pkt_hdr_vec_builder_pkg.sv | 26 ++
 rtl/pkt_hdr_vec_builder_keep_popcount.sv | 19 +
 rtl/pkt_hdr_vec_builder.sv | 165 ++++++++++++++++
 tb/tb_pkt_hdr_vec_builder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_hdr_vec_builder_pkg.sv
// Shared definitions for the packet header vector (PHV) writer and the
// reassembly/trim stage that consumes it.
//   PHV layout, LSB first:
//     [127:0]     first-beat tuser
//     [547:128]   reserved (match-stage containers), always zero here
//     [554:548]   tot_length, captured bytes, saturating at 127
//     [555+256k]  segment k, k = 0..NUM_SEGS-1
package pkt_hdr_vec_builder_pkg;

  localparam int SEG_W          = 256;
  localparam int NUM_SEGS       = 4;
  localparam int TUSER_W        = 128;
  localparam int KEEP_W         = SEG_W / 8;
  localparam int TOT_LENGTH_POS = 548;
  localparam int TOT_LENGTH_W   = 7;
  localparam int PKT_START_POS  = 555;
  localparam int PKT_VEC_WIDTH  = PKT_START_POS + SEG_W * NUM_SEGS;
  localparam int TOT_LENGTH_MAX = (1 << TOT_LENGTH_W) - 1;

  typedef enum logic [1:0] {
    ST_FIRST   = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SKIP    = 2'd2
  } phv_state_e;

endpackage

// File: rtl/pkt_hdr_vec_builder_keep_popcount.sv
// keep_popcount: number of set bits in a beat's byte-enable mask.
//   keep : byte enables, bit i qualifies byte i
//   cnt  : number of valid bytes in the beat (0..KEEP_W)
module keep_popcount #(
  parameter int KEEP_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic [KEEP_W-1:0] keep,
  output logic [CNT_W-1:0]  cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      cnt = cnt + CNT_W'(keep[i]);
    end
  end

endmodule

// File: rtl/pkt_hdr_vec_builder.sv
// pkt_hdr_vec_builder: snoops accepted AXIS beats, captures the first
// NUM_SEGS beats plus the first-beat tuser of each packet and emits one PHV
// per packet with a one-cycle parser_valid pulse.
//   clk, aresetn  : clock, synchronous active-low reset
//   s_axis_*      : qualified beat stream (tvalid already ANDed with ready)
//   parser_valid  : one-cycle pulse, pkt_hdr_vec is a new PHV
//   pkt_hdr_vec   : PHV, held between pulses
//   phv_cnt       : number of PHVs emitted, wraps
module pkt_hdr_vec_builder #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_SEGS             = 4,
  parameter int PKT_VEC_WIDTH        = 1579
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              parser_valid,
  output logic [PKT_VEC_WIDTH-1:0]          pkt_hdr_vec,
  output logic [31:0]                       phv_cnt
);
  import pkt_hdr_vec_builder_pkg::*;

  localparam int IDX_W  = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
  localparam int BYTE_W = $clog2(C_S_AXIS_DATA_WIDTH / 8 + 1);

  phv_state_e                                       state_q, state_d;
  logic [IDX_W-1:0]                                 seg_idx_q, seg_idx_d;
  logic [NUM_SEGS-1:0][C_S_AXIS_DATA_WIDTH-1:0]     seg_q, seg_d;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]                  tuser_q, tuser_d;
  logic [TOT_LENGTH_W-1:0]                          cnt_q, cnt_d;
  logic                                             parser_valid_q, parser_valid_d;
  logic [PKT_VEC_WIDTH-1:0]                         pkt_hdr_vec_q, pkt_hdr_vec_d;
  logic [31:0]                                      phv_cnt_q, phv_cnt_d;

  // Accumulator view including the current beat; this is what a trigger
  // publishes and what a non-trigger beat stores back.
  logic [NUM_SEGS-1:0][C_S_AXIS_DATA_WIDTH-1:0]     seg_cur;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]                  tuser_cur;
  logic [TOT_LENGTH_W-1:0]                          cnt_cur;
  logic [TOT_LENGTH_W:0]                            cnt_sum;
  logic [IDX_W-1:0]                                 wr_idx;
  logic [PKT_VEC_WIDTH-1:0]                         phv_cur;
  logic [BYTE_W-1:0]                                beat_bytes;
  logic                                             trigger;

  keep_popcount #(
    .KEEP_W (C_S_AXIS_DATA_WIDTH / 8),
    .CNT_W  (BYTE_W)
  ) u_keep_popcount (
    .keep (s_axis_tkeep),
    .cnt  (beat_bytes)
  );

  always_comb begin
    // A first beat starts from a clean accumulator regardless of what the
    // registers hold, so nothing from an earlier packet can leak in.
    seg_cur   = seg_q;
    tuser_cur = tuser_q;
    wr_idx    = seg_idx_q;
    cnt_sum   = {1'b0, cnt_q} + (TOT_LENGTH_W+1)'(beat_bytes);
    if (state_q == ST_FIRST) begin
      seg_cur   = '0;
      tuser_cur = s_axis_tuser;
      wr_idx    = '0;
      cnt_sum   = (TOT_LENGTH_W+1)'(beat_bytes);
    end
    seg_cur[wr_idx] = s_axis_tdata;
    cnt_cur = cnt_sum[TOT_LENGTH_W] ? TOT_LENGTH_W'(TOT_LENGTH_MAX)
                                    : cnt_sum[TOT_LENGTH_W-1:0];

    phv_cur = '0;
    phv_cur[C_S_AXIS_TUSER_WIDTH-1:0]            = tuser_cur;
    phv_cur[TOT_LENGTH_POS +: TOT_LENGTH_W]      = cnt_cur;
    for (int k = 0; k < NUM_SEGS; k++) begin
      phv_cur[PKT_START_POS + C_S_AXIS_DATA_WIDTH*k +: C_S_AXIS_DATA_WIDTH] = seg_cur[k];
    end
  end

  always_comb begin
    state_d        = state_q;
    seg_idx_d      = seg_idx_q;
    seg_d          = seg_q;
    tuser_d        = tuser_q;
    cnt_d          = cnt_q;
    parser_valid_d = 1'b0;
    pkt_hdr_vec_d  = pkt_hdr_vec_q;
    phv_cnt_d      = phv_cnt_q;
    trigger        = 1'b0;

    if (s_axis_tvalid) begin
      unique case (state_q)
        ST_FIRST: begin
          seg_d   = seg_cur;
          tuser_d = tuser_cur;
          cnt_d   = cnt_cur;
          if (s_axis_tlast) begin
            trigger = 1'b1;
          end else begin
            state_d   = ST_CAPTURE;
            seg_idx_d = IDX_W'(1);
          end
        end
        ST_CAPTURE: begin
          seg_d = seg_cur;
          cnt_d = cnt_cur;
          if (s_axis_tlast) begin
            trigger = 1'b1;
            state_d = ST_FIRST;
          end else if (seg_idx_q == IDX_W'(NUM_SEGS - 1)) begin
            // Capture window full: publish now, drop the tail.
            trigger = 1'b1;
            state_d = ST_SKIP;
          end else begin
            seg_idx_d = seg_idx_q + IDX_W'(1);
          end
        end
        ST_SKIP: begin
          if (s_axis_tlast) state_d = ST_FIRST;
        end
        default: state_d = ST_FIRST;
      endcase
    end

    if (trigger) begin
      pkt_hdr_vec_d  = phv_cur;
      parser_valid_d = 1'b1;
      phv_cnt_d      = phv_cnt_q + 32'd1;
      seg_d          = '0;
      cnt_d          = '0;
      seg_idx_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q        <= ST_FIRST;
      seg_idx_q      <= '0;
      seg_q          <= '0;
      tuser_q        <= '0;
      cnt_q          <= '0;
      parser_valid_q <= 1'b0;
      pkt_hdr_vec_q  <= '0;
      phv_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      seg_idx_q      <= seg_idx_d;
      seg_q          <= seg_d;
      tuser_q        <= tuser_d;
      cnt_q          <= cnt_d;
      parser_valid_q <= parser_valid_d;
      pkt_hdr_vec_q  <= pkt_hdr_vec_d;
      phv_cnt_q      <= phv_cnt_d;
    end
  end

  assign parser_valid = parser_valid_q;
  assign pkt_hdr_vec  = pkt_hdr_vec_q;
  assign phv_cnt      = phv_cnt_q;

endmodule

// File: tb/tb_pkt_hdr_vec_builder.sv
module tb_pkt_hdr_vec_builder;

  localparam int VW = 1579;

  logic           clk = 1'b0;
  logic           aresetn;
  logic [255:0]   s_axis_tdata;
  logic [127:0]   s_axis_tuser;
  logic [31:0]    s_axis_tkeep;
  logic           s_axis_tvalid;
  logic           s_axis_tlast;
  logic           parser_valid;
  logic [VW-1:0]  pkt_hdr_vec;
  logic [31:0]    phv_cnt;

  pkt_hdr_vec_builder dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .parser_valid  (parser_valid),
    .pkt_hdr_vec   (pkt_hdr_vec),
    .phv_cnt       (phv_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0]      user;
    logic [3:0][255:0] seg;
    int                tot;
    logic [31:0]       cnt;
    int                cyc;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: per-packet beat count, captured beats, byte total.
  int                m_n     = 0;
  logic [3:0][255:0] m_seg;
  logic [127:0]      m_user;
  int                m_bytes = 0;
  logic [31:0]       m_phv   = 0;
  logic [VW-1:0]     last_vec = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] build_vec(input exp_t e);
    logic [VW-1:0] v;
    v = '0;
    v[127:0]     = e.user;
    v[554:548]   = 7'(e.tot);
    for (int k = 0; k < 4; k++) v[555 + 256*k +: 256] = e.seg[k];
    return v;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Drive one accepted beat for the next rising edge and update the model.
  task automatic beat(input logic [255:0] d, input logic [127:0] u,
                      input logic [31:0] k, input logic l);
    exp_t e;
    @(negedge clk);
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    m_n++;
    if (m_n == 1) begin
      m_seg   = '0;
      m_user  = u;
      m_bytes = 0;
    end
    if (m_n <= 4) begin
      m_seg[m_n-1] = d;
      m_bytes += $countones(k);
      if (l || m_n == 4) begin
        m_phv++;
        e.user = m_user;
        e.seg  = m_seg;
        e.tot  = (m_bytes > 127) ? 127 : m_bytes;
        e.cnt  = m_phv;
        e.cyc  = cyc + 1;
        sb.push_back(e);
      end
    end
    if (l) m_n = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = rnd256();
      s_axis_tlast  = $urandom_range(0, 1) == 1;
      s_axis_tkeep  = $urandom;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    aresetn  = 1'b1;
    m_n      = 0;
    m_phv    = 0;
    last_vec = '0;
    chk("rst_valid", 256'(parser_valid), 256'(0));
    chk("rst_vec_nonzero", 256'(|pkt_hdr_vec), 256'(0));
    chk("rst_phv_cnt", 256'(phv_cnt), 256'(0));
  endtask

  // Monitor: every pulse must match the head of the scoreboard; between
  // pulses the vector must hold the last published PHV.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (aresetn) begin
      if (parser_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          chk("pulse_cycle", 256'(cyc), 256'(e.cyc));
          chk("tuser", 256'(pkt_hdr_vec[127:0]), 256'(e.user));
          chk("reserved_nonzero", 256'(|pkt_hdr_vec[547:128]), 256'(0));
          chk("tot_length", 256'(pkt_hdr_vec[554:548]), 256'(e.tot));
          for (int k = 0; k < 4; k++)
            chk($sformatf("seg%0d", k), pkt_hdr_vec[555 + 256*k +: 256], e.seg[k]);
          chk("phv_cnt", 256'(phv_cnt), 256'(e.cnt));
          last_vec = build_vec(e);
        end
      end else begin
        n_chk++;
        if (pkt_hdr_vec !== last_vec) begin
          n_fail++;
          $display("FAIL hold: got tot %0d seg0 %h expected tot %0d seg0 %h",
                   pkt_hdr_vec[554:548], pkt_hdr_vec[555 +: 256],
                   last_vec[554:548], last_vec[555 +: 256]);
        end
      end
    end
  end

  initial begin
    int len, gap;
    logic [31:0] kk;
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();

    // single beat, 16 bytes
    beat(rnd256(), {$urandom, $urandom, $urandom, $urandom}, 32'h0000FFFF, 1'b1);
    idle(3);
    // 3 beats, 72 bytes
    beat(rnd256(), {4{$urandom}}, 32'hFFFFFFFF, 1'b0);
    beat(rnd256(), {4{$urandom}}, 32'hFFFFFFFF, 1'b0);
    beat(rnd256(), {4{$urandom}}, 32'h000000FF, 1'b1);
    idle(2);
    // 6 full beats: saturated, tail dropped, then a normal packet
    for (int i = 0; i < 6; i++) beat(rnd256(), {4{$urandom}}, 32'hFFFFFFFF, i == 5);
    beat(rnd256(), {4{$urandom}}, 32'h0000000F, 1'b1);
    idle(2);
    // back-to-back single-beat packets
    beat(rnd256(), {4{$urandom}}, 32'hFFFFFFFF, 1'b1);
    beat(rnd256(), {4{$urandom}}, 32'h00FF00FF, 1'b1);
    idle(2);
    // 2 beats with idle gap
    beat(rnd256(), {4{$urandom}}, 32'hFFFFFFFF, 1'b0);
    idle(3);
    beat(rnd256(), {4{$urandom}}, 32'h0000FFFF, 1'b1);
    idle(2);
    // reset after beat 2 of a 4-beat packet; next beat is a fresh packet
    beat(rnd256(), {4{$urandom}}, 32'hFFFFFFFF, 1'b0);
    beat(rnd256(), {4{$urandom}}, 32'hFFFFFFFF, 1'b0);
    do_reset();
    beat(rnd256(), {4{$urandom}}, 32'h0000000F, 1'b1);
    idle(2);

    // randomized packets
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(1, 7);
      for (int b = 0; b < len; b++) begin
        case ($urandom_range(0, 3))
          0:       kk = 32'hFFFFFFFF;
          1:       kk = 32'hFFFFFFFF >> $urandom_range(0, 31);
          default: kk = $urandom;
        endcase
        beat(rnd256(), {$urandom, $urandom, $urandom, $urandom}, kk, b == len - 1);
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        if (gap > 0) idle(gap);
      end
    end
    idle(1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending PHVs expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
